// File: rtl/clk_div_buffer_if.sv
// Bundle of per-channel divide/enable requests and the divided clock outputs
// exchanged with clk_div_buffer.
interface clk_div_buffer_if #(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 8
);
    logic [NUM_CH*DIV_W-1:0] div;
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH-1:0]       bclk;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       run;

    modport master (
        output div,
        output en,
        input  bclk,
        input  tick,
        input  run
    );

    modport slave (
        input  div,
        input  en,
        output bclk,
        output tick,
        output run
    );
endinterface

// File: rtl/clk_div_buffer.sv
// NUM_CH independent 50%-duty, glitch-free divided clocks from mclk; enable and
// divide ratio take effect only at period boundaries. Define CLK_DIV_BUFFER_SYNC_EN to synchronise en.
module clk_div_buffer #(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 8
) (
    input logic             mclk,
    input logic             rst,
    clk_div_buffer_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q   [NUM_CH];
    state_t           state_d   [NUM_CH];
    logic [DIV_W-1:0] cnt_q     [NUM_CH];
    logic [DIV_W-1:0] cnt_d     [NUM_CH];
    logic [DIV_W-1:0] div_act_q [NUM_CH];
    logic [DIV_W-1:0] div_act_d [NUM_CH];
    logic [DIV_W-1:0] last_cnt  [NUM_CH];

    logic [NUM_CH-1:0] bclk_q;
    logic [NUM_CH-1:0] bclk_d;
    logic [NUM_CH-1:0] tick_q;
    logic [NUM_CH-1:0] tick_d;
    logic [NUM_CH-1:0] run_vec;
    logic [NUM_CH-1:0] en_use;

`ifdef CLK_DIV_BUFFER_SYNC_EN
    logic [NUM_CH-1:0] en_s1;
    logic [NUM_CH-1:0] en_s2;

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            en_s1 <= '0;
            en_s2 <= '0;
        end else begin
            en_s1 <= bus.en;
            en_s2 <= en_s1;
        end
    end

    assign en_use = en_s2;
`else
    assign en_use = bus.en;
`endif

    // A stored divide value of 0 is treated as a half-period of 1 cycle.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            last_cnt[i] = (div_act_q[i] == '0) ? '0 : div_act_q[i] - DIV_W'(1);
        end
    end

    always_comb begin
        bclk_d = bclk_q;
        tick_d = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            state_d[i]   = state_q[i];
            cnt_d[i]     = cnt_q[i];
            div_act_d[i] = div_act_q[i];
            unique case (state_q[i])
                IDLE: begin
                    bclk_d[i] = 1'b0;
                    cnt_d[i]  = '0;
                    if (en_use[i]) begin
                        state_d[i]   = RUN;
                        div_act_d[i] = bus.div[i*DIV_W +: DIV_W];
                        bclk_d[i]    = 1'b1;
                        tick_d[i]    = 1'b1;
                    end
                end
                RUN: begin
                    if (cnt_q[i] != last_cnt[i]) begin
                        cnt_d[i] = cnt_q[i] + DIV_W'(1);
                    end else begin
                        cnt_d[i] = '0;
                        if (bclk_q[i]) begin
                            bclk_d[i] = 1'b0;
                        end else if (en_use[i]) begin
                            // End of low phase is the only point where en/div are sampled.
                            div_act_d[i] = bus.div[i*DIV_W +: DIV_W];
                            bclk_d[i]    = 1'b1;
                            tick_d[i]    = 1'b1;
                        end else begin
                            state_d[i] = IDLE;
                        end
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            bclk_q <= '0;
            tick_q <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i]   <= IDLE;
                cnt_q[i]     <= '0;
                div_act_q[i] <= '0;
            end
        end else begin
            bclk_q <= bclk_d;
            tick_q <= tick_d;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i]   <= state_d[i];
                cnt_q[i]     <= cnt_d[i];
                div_act_q[i] <= div_act_d[i];
            end
        end
    end

    always_comb begin
        run_vec = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            run_vec[i] = (state_q[i] == RUN);
        end
    end

    assign bus.bclk = bclk_q;
    assign bus.tick = tick_q;
    assign bus.run  = run_vec;

endmodule

// File: tb/tb_clk_div_buffer.sv
// Directed bench for clk_div_buffer: expected {run,bclk,tick} per channel per
// cycle are queued from the ideal waveform and popped as the DUT runs.
module tb_clk_div_buffer;

`ifdef CLK_DIV_BUFFER_SYNC_EN
    localparam int unsigned LAT = 3;
`else
    localparam int unsigned LAT = 1;
`endif

    logic mclk = 1'b0;
    logic rst  = 1'b1;

    clk_div_buffer_if #(.NUM_CH(2), .DIV_W(8)) bus ();

    clk_div_buffer #(.NUM_CH(2), .DIV_W(8)) dut (
        .mclk (mclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 mclk = ~mclk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int cyc     = 0;

    logic [2:0] q0[$];
    logic [2:0] q1[$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // Ideal channel output k cycles after the rising edge of a run with half-period h.
    function automatic logic [2:0] wave(int unsigned k, int unsigned h);
        int unsigned ph;
        ph = k % (2 * h);
        return {1'b1, (ph < h), (ph == 0)};
    endfunction

    task automatic push(int ch, logic [2:0] v);
        if (ch == 0) q0.push_back(v);
        else         q1.push_back(v);
    endtask

    task automatic push_idle(int ch, int unsigned n);
        for (int unsigned k = 0; k < n; k++) push(ch, 3'b000);
    endtask

    task automatic push_run(int ch, int unsigned h, int unsigned periods);
        for (int unsigned k = 0; k < 2 * h * periods; k++) push(ch, wave(k, h));
    endtask

    task automatic run_cycles(int unsigned n);
        logic [2:0] e0, e1;
        for (int unsigned c = 0; c < n; c++) begin
            @(posedge mclk);
            #1;
            cyc++;
            e0 = (q0.size() > 0) ? q0.pop_front() : 3'bxxx;
            e1 = (q1.size() > 0) ? q1.pop_front() : 3'bxxx;
            chk("ch0", 32'({bus.run[0], bus.bclk[0], bus.tick[0]}), 32'(e0));
            chk("ch1", 32'({bus.run[1], bus.bclk[1], bus.tick[1]}), 32'(e1));
        end
    endtask

    // Reset asserted between edges: outputs must clear without waiting for mclk.
    task automatic do_reset(string tag);
        chk({tag, "_drain"}, 32'(q0.size() + q1.size()), 32'd0);
        @(negedge mclk);
        rst = 1'b1;
        #1;
        chk({tag, "_async_rst"}, 32'({bus.run, bus.bclk, bus.tick}), 32'd0);
        bus.en = '0;
        @(negedge mclk);
        @(negedge mclk);
        rst = 1'b0;
        q0.delete();
        q1.delete();
    endtask

    initial begin
        bus.en  = '0;
        bus.div = '0;
        #3;
        chk("rst_t0", 32'({bus.run, bus.bclk, bus.tick}), 32'd0);
        repeat (2) @(posedge mclk);
        #1;
        chk("rst_held", 32'({bus.run, bus.bclk, bus.tick}), 32'd0);
        @(negedge mclk);
        rst = 1'b0;

        // ch0 div=1: mclk/2, first rise LAT cycles after en
        bus.div = {8'd0, 8'd1};
        bus.en  = 2'b01;
        push_idle(0, LAT - 1);
        push_run(0, 1, 4);
        push_idle(1, LAT - 1 + 8);
        run_cycles(LAT - 1 + 8);
        do_reset("div1");

        // ch0 div=3 (3 high / 3 low); ch1 div=0 behaves as div=1
        bus.div = {8'd0, 8'd3};
        bus.en  = 2'b11;
        push_idle(0, LAT - 1);
        push_run(0, 3, 3);
        push_idle(1, LAT - 1);
        push_run(1, 1, 9);
        run_cycles(LAT - 1 + 18);
        do_reset("div3_div0");

        // ch0 div 3 -> 5 during the first high phase: 3/3 period, then 5/5
        bus.div = {8'd0, 8'd3};
        bus.en  = 2'b01;
        push_idle(0, LAT - 1);
        push_run(0, 3, 1);
        push_run(0, 5, 2);
        push_idle(1, LAT - 1 + 26);
        run_cycles(LAT);
        run_cycles(1);
        bus.div[7:0] = 8'd5;
        run_cycles(24);
        do_reset("div_change");

        // ch1 div=4 stopped one cycle after rising; ch0 div=2 keeps running
        bus.div = {8'd4, 8'd2};
        bus.en  = 2'b11;
        push_idle(0, LAT - 1);
        push_run(0, 2, 4);
        push_idle(1, LAT - 1);
        push_run(1, 4, 1);
        push_idle(1, 8);
        run_cycles(LAT);
        run_cycles(1);
        bus.en[1] = 1'b0;
        run_cycles(14);
        do_reset("en_drop");

        // ch1 maximum half-period 255, en dropped right after the rise
        bus.div = {8'd255, 8'd0};
        bus.en  = 2'b10;
        push_idle(0, LAT - 1 + 514);
        push_idle(1, LAT - 1);
        push_run(1, 255, 1);
        push_idle(1, 4);
        run_cycles(LAT);
        bus.en = 2'b00;
        run_cycles(513);
        do_reset("div_max");

        // ch0 stops at a boundary, en returns just after: extra idle low cycle(s)
        bus.div = {8'd0, 8'd2};
        bus.en  = 2'b01;
        push_idle(0, LAT - 1);
        push_run(0, 2, 1);
        push_idle(0, LAT);
        push_run(0, 2, 1);
        push_idle(1, 2 * LAT + 7);
        run_cycles(LAT);
        bus.en = 2'b00;
        run_cycles(4);
        bus.en = 2'b01;
        run_cycles(LAT + 3);
        do_reset("restart");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
